// File: rtl/cmul_lanes_elastic.sv
// Multi-lane constant-coefficient multiplier: round, saturate or wrap, then a
// fixed-latency pipeline feeding a credit-reserved output FIFO.
module cmul_lanes_elastic #(
  parameter int                      LANES = 4,
  parameter int                      DATAW = 16,
  parameter int                      COEFW = 16,
  parameter logic signed [COEFW-1:0] COEF  = 16'sh0180,
  parameter int                      FRAC  = 8,
  parameter int                      SAT   = 1,
  parameter int                      PIPE  = 3,
  parameter int                      DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ivalid,
  output logic                   iready,
  input  logic [LANES*DATAW-1:0] in_data,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [LANES*DATAW-1:0] out_data,
  output logic [LANES-1:0]       osat
);

  localparam int PW   = DATAW + COEFW;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = $clog2(DEPTH);

  // One guard bit above the product so the rounding add cannot overflow.
  localparam logic signed [PW:0] RND  = (FRAC > 0) ?
      ({{PW{1'b0}}, 1'b1} << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic signed [PW:0] MAXV = {{(PW-DATAW+2){1'b0}}, {(DATAW-1){1'b1}}};
  localparam logic signed [PW:0] MINV = {{(PW-DATAW+2){1'b1}}, {(DATAW-1){1'b0}}};

  if (PIPE < 1) begin : g_bad_pipe
    $error("cmul_lanes_elastic: PIPE must be at least 1");
  end
  if (DEPTH < PIPE + 1) begin : g_bad_depth
    $error("cmul_lanes_elastic: DEPTH must be at least PIPE+1");
  end

  logic accept, pop, wr;
  logic [LANES*DATAW-1:0] res_data;
  logic [LANES-1:0]       res_sat;

  // ---------------- per-lane arithmetic ----------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATAW-1:0] lane_s;
    logic signed [PW:0]      prod;
    logic signed [PW:0]      rnd;
    logic                    over, under;

    assign lane_s = in_data[i*DATAW +: DATAW];
    assign prod   = $signed({{(COEFW+1){lane_s[DATAW-1]}}, lane_s}) *
                    $signed({{(DATAW+1){COEF[COEFW-1]}}, COEF});
    assign rnd    = (prod + RND) >>> FRAC;
    assign over   = rnd > MAXV;
    assign under  = rnd < MINV;

    assign res_data[i*DATAW +: DATAW] =
        ((SAT != 0) && over)  ? MAXV[DATAW-1:0] :
        ((SAT != 0) && under) ? MINV[DATAW-1:0] : rnd[DATAW-1:0];
    assign res_sat[i] = (SAT != 0) && (over || under);
  end

  // ---------------- pipeline ----------------
  logic [PIPE-1:0]        pv_q;
  logic [LANES*DATAW-1:0] pd_q [PIPE];
  logic [LANES-1:0]       ps_q [PIPE];

  // ---------------- credit counter and FIFO state ----------------
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] occ_q, occ_d;
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;

  logic [LANES*DATAW-1:0] fifo_data [DEPTH];
  logic [LANES-1:0]       fifo_sat  [DEPTH];

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Credits cover the whole pipeline, so a sample is only taken when a FIFO slot is reserved.
  assign iready = rst & (cnt_q < CNTW'(DEPTH));
  assign accept = ivalid & iready;
  assign ovalid = (occ_q != '0);
  assign pop    = ovalid & oready;
  assign wr     = pv_q[PIPE-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d  = cnt_q;
    occ_d  = occ_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CNTW'(accept) - CNTW'(pop);
    occ_d  = occ_q + CNTW'(wr) - CNTW'(pop);
    if (wr)  wptr_d = ptr_inc(wptr_q);
    if (pop) rptr_d = ptr_inc(rptr_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      occ_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      pv_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      pv_q[0] <= accept;
      for (int i = 1; i < PIPE; i++) pv_q[i] <= pv_q[i-1];
    end
  end

  // NOTE: data storage is deliberately not reset; valid bits and occupancy qualify it.
  always_ff @(posedge clk) begin
    pd_q[0] <= res_data;
    ps_q[0] <= res_sat;
    for (int i = 1; i < PIPE; i++) begin
      pd_q[i] <= pd_q[i-1];
      ps_q[i] <= ps_q[i-1];
    end
    if (wr) begin
      fifo_data[wptr_q] <= pd_q[PIPE-1];
      fifo_sat[wptr_q]  <= ps_q[PIPE-1];
    end
  end

  // Head is forced to zero when empty so reset and idle outputs are clean.
  assign out_data = ovalid ? fifo_data[rptr_q] : '0;
  assign osat     = ovalid ? fifo_sat[rptr_q]  : '0;

endmodule

// File: tb/tb_cmul_lanes_elastic.sv
// Directed bench for cmul_lanes_elastic: reset, arithmetic corners, back-pressure,
// randomised handshake against a reference model, and mid-stream reset.
module tb_cmul_lanes_elastic;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid, iready, ovalid, oready;
  logic [63:0] in_data, out_data;
  logic [3:0]  osat;
  logic        ivalid_w, iready_w, ovalid_w, oready_w;
  logic [63:0] in_data_w, out_data_w;
  logic [3:0]  osat_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmul_lanes_elastic #(.SAT(1)) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready), .in_data(in_data),
    .ovalid(ovalid), .oready(oready), .out_data(out_data), .osat(osat)
  );

  cmul_lanes_elastic #(.SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .ivalid(ivalid_w), .iready(iready_w), .in_data(in_data_w),
    .ovalid(ovalid_w), .oready(oready_w), .out_data(out_data_w), .osat(osat_w)
  );

  // Reference: x * 1.5 with round-half-up, saturated to 16 bits. Returns {sat, data}.
  function automatic logic [67:0] model(input logic [63:0] din);
    logic [63:0] d;
    logic [3:0]  s;
    logic [15:0] lane;
    longint      x, r;
    d = '0;
    s = '0;
    for (int j = 0; j < 4; j++) begin
      lane = din[j*16 +: 16];
      x    = longint'($signed(lane));
      r    = (x * 384 + 128) >>> 8;
      if (r > 32767)       begin d[j*16 +: 16] = 16'h7FFF; s[j] = 1'b1; end
      else if (r < -32768) begin d[j*16 +: 16] = 16'h8000; s[j] = 1'b1; end
      else                 d[j*16 +: 16] = r[15:0];
    end
    return {s, d};
  endfunction

  function automatic logic [63:0] bp_vec(input int k);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(10 * k + 2 * j);
    return v;
  endfunction

  function automatic logic [63:0] bp_exp(input int k);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(15 * k + 3 * j);
    return v;
  endfunction

  task automatic send_one(input logic [63:0] din);
    @(posedge clk); #1;
    ivalid  = 1'b1;
    in_data = din;
    @(posedge clk); #1;
    ivalid  = 1'b0;
  endtask

  // Waits (bounded) for a head entry, pops it and returns what was seen.
  task automatic pop_one(output logic [63:0] d, output logic [3:0] s, output bit got);
    got = 1'b0;
    d   = '0;
    s   = '0;
    @(posedge clk); #1;
    oready = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (ovalid === 1'b1) begin got = 1'b1; d = out_data; s = osat; end
    end
    @(posedge clk); #1;
    oready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ivalid = 1'b0; oready = 1'b0; in_data = '0;
    ivalid_w = 1'b0; oready_w = 1'b0; in_data_w = '0;
    #12;
    total++; if (ovalid !== 1'b0)    begin bad++; $display("FAIL reset_ovalid: got %b want 0", ovalid); end
    total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (osat !== 4'h0)      begin bad++; $display("FAIL reset_osat: got %b want 0", osat); end
    total++; if (iready !== 1'b0)    begin bad++; $display("FAIL reset_iready: got %b want 0", iready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (iready !== 1'b1)    begin bad++; $display("FAIL release_iready: got %b want 1", iready); end
  endtask

  task automatic test_basic();
    int          lat;
    logic [63:0] d;
    logic [3:0]  s;
    bit          got;
    @(posedge clk); #1;
    ivalid  = 1'b1;
    in_data = {4{16'd100}};
    @(negedge clk);
    total++; if (iready !== 1'b1) begin bad++; $display("FAIL basic_accept: iready=%b want 1", iready); end
    @(posedge clk); #1;
    ivalid = 1'b0;
    lat = -1;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (ovalid === 1'b1 && lat < 0) lat = i;
    end
    total++; if (lat != 3) begin bad++; $display("FAIL basic_latency: got %0d want 3", lat); end
    total++; if (out_data !== {4{16'd150}}) begin bad++; $display("FAIL basic_data: got %h want %h", out_data, {4{16'd150}}); end
    total++; if (osat !== 4'h0) begin bad++; $display("FAIL basic_osat: got %b want 0000", osat); end
    pop_one(d, s, got);
    @(negedge clk);
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL basic_drain: ovalid=%b want 0", ovalid); end
  endtask

  task automatic test_rounding();
    logic [63:0] d;
    logic [3:0]  s;
    bit          got;
    send_one({16'd0, 16'd1, 16'hFFFD, 16'd3});
    pop_one(d, s, got);
    total++; if (!got) begin bad++; $display("FAIL round_timeout: got no output want one"); end
    total++; if (d !== {16'd0, 16'd2, 16'hFFFC, 16'd5})
      begin bad++; $display("FAIL round_data: got %h want %h", d, {16'd0, 16'd2, 16'hFFFC, 16'd5}); end
    total++; if (s !== 4'h0) begin bad++; $display("FAIL round_osat: got %b want 0000", s); end
  endtask

  task automatic test_saturation();
    logic [63:0] d;
    logic [3:0]  s;
    bit          got;
    @(posedge clk); #1;
    ivalid = 1'b1; ivalid_w = 1'b1;
    in_data   = {16'h7000, 16'h0064, 16'h8000, 16'h7000};
    in_data_w = {16'h7000, 16'h0064, 16'h8000, 16'h7000};
    @(posedge clk); #1;
    ivalid = 1'b0; ivalid_w = 1'b0;
    pop_one(d, s, got);
    total++; if (d !== {16'h7FFF, 16'h0096, 16'h8000, 16'h7FFF})
      begin bad++; $display("FAIL sat_data: got %h want %h", d, {16'h7FFF, 16'h0096, 16'h8000, 16'h7FFF}); end
    total++; if (s !== 4'b1011) begin bad++; $display("FAIL sat_osat: got %b want 1011", s); end
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ovalid_w === 1'b1) break;
    end
    total++; if (ovalid_w !== 1'b1) begin bad++; $display("FAIL wrap_timeout: ovalid=%b want 1", ovalid_w); end
    total++; if (out_data_w !== {16'hA800, 16'h0096, 16'h4000, 16'hA800})
      begin bad++; $display("FAIL wrap_data: got %h want %h", out_data_w, {16'hA800, 16'h0096, 16'h4000, 16'hA800}); end
    total++; if (osat_w !== 4'h0) begin bad++; $display("FAIL wrap_osat: got %b want 0000", osat_w); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int drop_cyc = -1;
    int rx = 0;
    int cyc = 0;
    oready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      ivalid  = 1'b1;
      in_data = bp_vec(acc);
      @(negedge clk);
      if (iready === 1'b1) acc++;
      else if (drop_cyc < 0) drop_cyc = c;
    end
    total++; if (acc != 8)      begin bad++; $display("FAIL bp_accepts: got %0d want 8", acc); end
    total++; if (drop_cyc != 8) begin bad++; $display("FAIL bp_iready_drop: cycle %0d want 8", drop_cyc); end
    while (rx < 20 && cyc < 200) begin
      @(posedge clk); #1;
      oready  = 1'b1;
      ivalid  = (acc < 20);
      in_data = bp_vec(acc);
      @(negedge clk);
      if (ivalid && iready === 1'b1) acc++;
      if (ovalid === 1'b1) begin
        total++;
        if (out_data !== bp_exp(rx) || osat !== 4'h0) begin
          bad++;
          $display("FAIL bp_out%0d: got %h/%b want %h/0000", rx, out_data, osat, bp_exp(rx));
        end
        rx++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    ivalid = 1'b0; oready = 1'b0;
    total++; if (rx != 20)  begin bad++; $display("FAIL bp_count: got %0d outputs want 20", rx); end
    total++; if (cyc != 20) begin bad++; $display("FAIL bp_gaps: drain took %0d cycles want 20", cyc); end
  endtask

  task automatic test_random();
    logic [67:0] q[$];
    logic [67:0] exp_v;
    int sent = 0;
    int rx = 0;
    int cyc = 0;
    int cnt_viol = 0;
    while (rx < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      ivalid  = (sent < 10000) && ($urandom_range(1, 0) == 1);
      in_data = {$urandom(), $urandom()};
      oready  = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      if (ivalid && iready === 1'b1) begin q.push_back(model(in_data)); sent++; end
      if (ovalid === 1'b1 && oready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_extra: got %h with nothing expected", out_data);
        end else begin
          exp_v = q.pop_front();
          if ({osat, out_data} !== exp_v) begin
            bad++; $display("FAIL rand_out%0d: got %h want %h", rx, {osat, out_data}, exp_v);
          end
        end
        rx++;
      end
      if (dut.cnt_q > 4'(DEPTH)) cnt_viol++;
      cyc++;
    end
    @(posedge clk); #1;
    ivalid = 1'b0; oready = 1'b0;
    total++; if (rx != 10000) begin bad++; $display("FAIL rand_count: got %0d outputs want 10000", rx); end
    total++; if (cnt_viol != 0) begin bad++; $display("FAIL rand_credit: %0d cycles with cnt above %0d want 0", cnt_viol, DEPTH); end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    oready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      ivalid  = 1'b1;
      in_data = bp_vec(k + 1);
    end
    @(posedge clk); #1;
    ivalid = 1'b0;
    total++; if (ovalid !== 1'b1) begin bad++; $display("FAIL mid_prefill: ovalid=%b want 1", ovalid); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (ovalid !== 1'b0)    begin bad++; $display("FAIL mid_ovalid: got %b want 0", ovalid); end
    total++; if (out_data !== 64'h0) begin bad++; $display("FAIL mid_out_data: got %h want 0", out_data); end
    total++; if (iready !== 1'b0)    begin bad++; $display("FAIL mid_iready: got %b want 0", iready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (iready !== 1'b1) begin bad++; $display("FAIL mid_release_iready: got %b want 1", iready); end
    oready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ovalid !== 1'b0) stale++;
    end
    oready = 1'b0;
    total++; if (stale != 0) begin bad++; $display("FAIL mid_stale: %0d cycles with output want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
